alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Two-stage pipelined integer execution unit sitting directly downstream of `alu_control`. It consumes the registered `ALUOp` code together with the operands and per-hart tag launched in the same cycle, and returns a registered 32-bit result plus comparison flags two cycles later. Valid and hart-ID tracking travel with each operation so the barrel pipeline can interleave harts every cycle. A flush input kills in-flight operations.

## Interface
- `DATA_WIDTH`, 32: operand/result width.
- `HART_ID_WIDTH`, 4: width of the hart tag carried through the stage.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  operation present on inputs this cycle.
- `i_ALUOp`  in  ALUOP_WIDTH  operation code from `alu_control` (riscv_pkg encodings).
- `i_op_a`  in  DATA_WIDTH  first operand.
- `i_op_b`  in  DATA_WIDTH  second operand (register or immediate).
- `i_hart_id`  in  HART_ID_WIDTH  issuing hart tag.
- `i_flush`  in  1  kill all in-flight and incoming operations.
- `o_valid`  out  1  result valid.
- `o_result`  out  DATA_WIDTH  operation result.
- `o_zero`  out  1  `o_result == 0`.
- `o_lt`  out  1  signed `op_a < op_b` of the same operation.
- `o_ltu`  out  1  unsigned `op_a < op_b` of the same operation.
- `o_hart_id`  out  HART_ID_WIDTH  tag of the operation on `o_result`.

## Operation
- Stage 1 (capture): on each edge registers `i_ALUOp`, `i_op_a`, `i_op_b`, `i_hart_id`; `s1_valid <= i_valid & ~i_flush`.
- Stage 2 (compute): combinational ALU over stage-1 registers; on each edge registers result, flags, hart ID; `o_valid <= s1_valid & ~i_flush`.
- Operation set (ALUOp constant → result):
  - ADD_OP: a + b, modulo 2^32, carry discarded.
  - SUB_OP: a − b, modulo 2^32.
  - SLL_OP: a << b[4:0]; SRL_OP: logical a >> b[4:0]; SRA_OP: arithmetic a >>> b[4:0]. Bits b[31:5] ignored.
  - SLT_OP: {31'b0, signed a<b}; SLTU_OP: {31'b0, unsigned a<b}.
  - XOR_OP, OR_OP, AND_OP: bitwise.
  - PASS_OP: b.
  - Any other code (including the all-zero undefined code): result 0.
- `o_lt`/`o_ltu` computed for every op from the operands regardless of ALUOp; `o_zero` from the final result.
- Data registers load every cycle independent of valid; only valid bits are gated by flush. Downstream qualifies all outputs with `o_valid`.
- No backpressure: one operation accepted per cycle, no stalls, no ready signal.

## Timing
- Latency: operation presented at edge N (inputs sampled) → `o_valid`/`o_result` visible after edge N+1, i.e. 2 cycles from input cycle to output cycle; throughput 1/cycle.
- `i_ALUOp` must be aligned by the upstream pipeline with operands of the same instruction (alu_control's own register stage is accounted for upstream).
- Flush: `i_flush` high in cycle C clears `s1_valid` and `o_valid` at the next edge; the operation sampled in C and the one in stage 1 are both dropped; the one already on the output in C is unaffected (it was visible during C).
- Flush and `i_valid` together: input dropped. Flush held multiple cycles: outputs stay invalid; first valid after flush deasserts appears 2 cycles later.
- Reset: asynchronous assertion immediately clears `s1_valid`, `o_valid`, `o_result`, `o_zero`, `o_lt`, `o_ltu`, `o_hart_id`, all stage-1 registers to 0. Reset mid-operation discards everything in flight. First operation after reset release is accepted on the first clock edge with `reset` low.

## Test plan
- Back-to-back ops, hart IDs 0..3: ADD 5+7, SUB 3−5, SLT −1<1, SLTU 0xFFFFFFFF<1 → results 12, 0xFFFFFFFE, 1, 0 on consecutive cycles, 2-cycle latency, hart IDs preserved in order.
- Shifts: a=0x80000000, b=0x00000024 (shamt 4): SLL → 0, SRL → 0x08000000, SRA → 0xF8000000.
- Logic/PASS/undefined: a=0xF0F0F0F0, b=0x0FF00FF0: XOR → 0xFF00FF00, OR → 0xFFF0FFF0, AND → 0x00F000F0, PASS → 0x0FF00FF0, code 0 → 0 with `o_zero`=1.
- Flags: SUB a=b=0x1234 → result 0, `o_zero`=1, `o_lt`=0, `o_ltu`=0; a=0x80000000, b=1 → `o_lt`=1, `o_ltu`=0.
- Flush: four valid ops issued cycles 0–3, `i_flush` high in cycle 2 → ops from cycles 1 and 2 never produce `o_valid`; op 0 output in cycle 2, op 3 output in cycle 5.
- Reset mid-stream: assert `reset` asynchronously between edges with two ops in flight → all outputs 0 immediately, no `o_valid` for either; op issued first cycle after release appears 2 cycles later.

Source files
------------

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - two-stage pipelined integer ALU with valid/hart tracking and flush
// Stage 1 captures the operation; stage 2 computes the result and registers it with flags and tag.
module alu_exec_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int HART_ID_WIDTH = 4,
  parameter int ALUOP_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [ALUOP_WIDTH-1:0]   i_ALUOp,
  input  logic [DATA_WIDTH-1:0]    i_op_a,
  input  logic [DATA_WIDTH-1:0]    i_op_b,
  input  logic [HART_ID_WIDTH-1:0] i_hart_id,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_result,
  output logic                     o_zero,
  output logic                     o_lt,
  output logic                     o_ltu,
  output logic [HART_ID_WIDTH-1:0] o_hart_id
);

  // ALUOp encodings shared with alu_control; code 0 is deliberately undefined.
  localparam logic [ALUOP_WIDTH-1:0] ADD_OP  = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] SUB_OP  = ALUOP_WIDTH'(2);
  localparam logic [ALUOP_WIDTH-1:0] SLL_OP  = ALUOP_WIDTH'(3);
  localparam logic [ALUOP_WIDTH-1:0] SLT_OP  = ALUOP_WIDTH'(4);
  localparam logic [ALUOP_WIDTH-1:0] SLTU_OP = ALUOP_WIDTH'(5);
  localparam logic [ALUOP_WIDTH-1:0] XOR_OP  = ALUOP_WIDTH'(6);
  localparam logic [ALUOP_WIDTH-1:0] SRL_OP  = ALUOP_WIDTH'(7);
  localparam logic [ALUOP_WIDTH-1:0] SRA_OP  = ALUOP_WIDTH'(8);
  localparam logic [ALUOP_WIDTH-1:0] OR_OP   = ALUOP_WIDTH'(9);
  localparam logic [ALUOP_WIDTH-1:0] AND_OP  = ALUOP_WIDTH'(10);
  localparam logic [ALUOP_WIDTH-1:0] PASS_OP = ALUOP_WIDTH'(11);

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  logic                     s1_valid;
  logic [ALUOP_WIDTH-1:0]   s1_op;
  logic [DATA_WIDTH-1:0]    s1_a;
  logic [DATA_WIDTH-1:0]    s1_b;
  logic [HART_ID_WIDTH-1:0] s1_hart;

  logic [SHAMT_WIDTH-1:0]   shamt;
  logic                     lt_s;
  logic                     lt_u;
  logic [DATA_WIDTH-1:0]    alu_result;

  // Data registers load every cycle; only the valid bit is gated by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_hart  <= '0;
    end else begin
      s1_valid <= i_valid & ~i_flush;
      s1_op    <= i_ALUOp;
      s1_a     <= i_op_a;
      s1_b     <= i_op_b;
      s1_hart  <= i_hart_id;
    end
  end

  assign shamt = s1_b[SHAMT_WIDTH-1:0];
  assign lt_s  = $signed(s1_a) < $signed(s1_b);
  assign lt_u  = s1_a < s1_b;

  always_comb begin
    alu_result = '0;
    case (s1_op)
      ADD_OP:  alu_result = s1_a + s1_b;
      SUB_OP:  alu_result = s1_a - s1_b;
      SLL_OP:  alu_result = s1_a << shamt;
      SRL_OP:  alu_result = s1_a >> shamt;
      SRA_OP:  alu_result = $unsigned($signed(s1_a) >>> shamt);
      SLT_OP:  alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      SLTU_OP: alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      XOR_OP:  alu_result = s1_a ^ s1_b;
      OR_OP:   alu_result = s1_a | s1_b;
      AND_OP:  alu_result = s1_a & s1_b;
      PASS_OP: alu_result = s1_b;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_zero    <= 1'b0;
      o_lt      <= 1'b0;
      o_ltu     <= 1'b0;
      o_hart_id <= '0;
    end else begin
      o_valid   <= s1_valid & ~i_flush;
      o_result  <= alu_result;
      o_zero    <= (alu_result == '0);
      o_lt      <= lt_s;
      o_ltu     <= lt_u;
      o_hart_id <= s1_hart;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed-vector bench for alu_exec_stage
module tb_alu_exec_stage;

  localparam logic [3:0] ADD_OP  = 4'd1;
  localparam logic [3:0] SUB_OP  = 4'd2;
  localparam logic [3:0] SLL_OP  = 4'd3;
  localparam logic [3:0] SLT_OP  = 4'd4;
  localparam logic [3:0] SLTU_OP = 4'd5;
  localparam logic [3:0] XOR_OP  = 4'd6;
  localparam logic [3:0] SRL_OP  = 4'd7;
  localparam logic [3:0] SRA_OP  = 4'd8;
  localparam logic [3:0] OR_OP   = 4'd9;
  localparam logic [3:0] AND_OP  = 4'd10;
  localparam logic [3:0] PASS_OP = 4'd11;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [3:0]  i_ALUOp;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [3:0]  i_hart_id;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_lt;
  logic        o_ltu;
  logic [3:0]  o_hart_id;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  hart;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        ltu;
  } vec_t;

  vec_t vq[$];

  alu_exec_stage #(.DATA_WIDTH(32), .HART_ID_WIDTH(4), .ALUOP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ALUOp(i_ALUOp),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_hart_id(i_hart_id), .i_flush(i_flush),
    .o_valid(o_valid), .o_result(o_result), .o_zero(o_zero), .o_lt(o_lt),
    .o_ltu(o_ltu), .o_hart_id(o_hart_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] hart, input logic [31:0] res,
                         input logic z, input logic lt, input logic ltu);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hart = hart;
    v.res = res; v.z = z; v.lt = lt; v.ltu = ltu;
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    i_valid = 1'b0; i_ALUOp = 4'd0; i_op_a = '0; i_op_b = '0; i_hart_id = '0;
  endtask

  // Issue queued vectors back to back; each result must appear exactly two cycles later.
  task automatic run_vecs(input string grp);
    int n;
    n = vq.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i < 2) begin
        check({grp, "_lat_valid"}, {31'b0, o_valid}, 32'd0);
      end else begin
        check({grp, "_valid"},  {31'b0, o_valid},  32'd1);
        check({grp, "_result"}, o_result,          vq[i-2].res);
        check({grp, "_zero"},   {31'b0, o_zero},   {31'b0, vq[i-2].z});
        check({grp, "_lt"},     {31'b0, o_lt},     {31'b0, vq[i-2].lt});
        check({grp, "_ltu"},    {31'b0, o_ltu},    {31'b0, vq[i-2].ltu});
        check({grp, "_hart"},   {28'b0, o_hart_id}, {28'b0, vq[i-2].hart});
      end
      if (i < n) begin
        i_valid = 1'b1; i_ALUOp = vq[i].op; i_op_a = vq[i].a;
        i_op_b = vq[i].b; i_hart_id = vq[i].hart;
      end else begin
        drive_idle();
      end
    end
    @(negedge clk);
    check({grp, "_drain"}, {31'b0, o_valid}, 32'd0);
    vq.delete();
  endtask

  initial begin
    reset = 1'b1; i_flush = 1'b0;
    drive_idle();
    #1;
    check("rst_valid",  {31'b0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_flags",  {29'b0, o_zero, o_lt, o_ltu}, 32'd0);
    check("rst_hart",   {28'b0, o_hart_id}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    add_vec(ADD_OP,  32'd5,        32'd7, 4'd0, 32'd12,         1'b0, 1'b1, 1'b1);
    add_vec(SUB_OP,  32'd3,        32'd5, 4'd1, 32'hFFFFFFFE,   1'b0, 1'b1, 1'b1);
    add_vec(SLT_OP,  32'hFFFFFFFF, 32'd1, 4'd2, 32'd1,          1'b0, 1'b1, 1'b0);
    add_vec(SLTU_OP, 32'hFFFFFFFF, 32'd1, 4'd3, 32'd0,          1'b1, 1'b1, 1'b0);
    run_vecs("arith");

    add_vec(SLL_OP, 32'h80000000, 32'h24, 4'd4, 32'h00000000, 1'b1, 1'b1, 1'b0);
    add_vec(SRL_OP, 32'h80000000, 32'h24, 4'd5, 32'h08000000, 1'b0, 1'b1, 1'b0);
    add_vec(SRA_OP, 32'h80000000, 32'h24, 4'd6, 32'hF8000000, 1'b0, 1'b1, 1'b0);
    run_vecs("shift");

    add_vec(XOR_OP,  32'hF0F0F0F0, 32'h0FF00FF0, 4'd7,  32'hFF00FF00, 1'b0, 1'b1, 1'b0);
    add_vec(OR_OP,   32'hF0F0F0F0, 32'h0FF00FF0, 4'd8,  32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
    add_vec(AND_OP,  32'hF0F0F0F0, 32'h0FF00FF0, 4'd9,  32'h00F000F0, 1'b0, 1'b1, 1'b0);
    add_vec(PASS_OP, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd10, 32'h0FF00FF0, 1'b0, 1'b1, 1'b0);
    add_vec(4'd0,    32'hF0F0F0F0, 32'h0FF00FF0, 4'd11, 32'h00000000, 1'b1, 1'b1, 1'b0);
    add_vec(4'd12,   32'hF0F0F0F0, 32'h0FF00FF0, 4'd12, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_vecs("logic");

    add_vec(SUB_OP, 32'h1234,     32'h1234, 4'd13, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add_vec(ADD_OP, 32'h80000000, 32'd1,    4'd14, 32'h80000001, 1'b0, 1'b1, 1'b0);
    run_vecs("flags");

    // Flush: ops in cycles 0..3, flush in cycle 2; only ops 0 and 3 survive.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("flush_valid_c%0d", c), {31'b0, o_valid},
            (c == 2 || c == 5) ? 32'd1 : 32'd0);
      if (c == 2) check("flush_op0_result", o_result, 32'd101);
      if (c == 5) check("flush_op3_result", o_result, 32'd104);
      if (c < 4) begin
        i_valid = 1'b1; i_ALUOp = ADD_OP; i_op_a = 32'd100;
        i_op_b = 32'(c + 1); i_hart_id = 4'(c);
      end else begin
        drive_idle();
      end
      i_flush = (c == 2);
    end

    // Reset mid-stream with one op on the output and another in stage 1.
    @(negedge clk);
    i_valid = 1'b1; i_ALUOp = ADD_OP; i_op_a = 32'd1; i_op_b = 32'd2; i_hart_id = 4'd5;
    @(negedge clk);
    i_ALUOp = OR_OP; i_op_a = 32'h10; i_op_b = 32'h01; i_hart_id = 4'd6;
    @(posedge clk);
    drive_idle();
    #2;
    check("prerst_valid", {31'b0, o_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_valid",  {31'b0, o_valid}, 32'd0);
    check("midrst_result", o_result, 32'd0);
    check("midrst_flags",  {29'b0, o_zero, o_lt, o_ltu}, 32'd0);
    check("midrst_hart",   {28'b0, o_hart_id}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    add_vec(ADD_OP, 32'd20, 32'd22, 4'd9, 32'd42, 1'b0, 1'b1, 1'b1);
    run_vecs("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
